adc_capture_packer: RTL and testbench
=====================================

Name: adc_capture_packer

Overview:
- Downstream consumer of the 16-to-32-bit ADC word extender.
- Takes the extender's 32-bit word and its every-other-cycle valid strobe, and captures a software-set number of words on a start command.
- Emits the captured words as one AXI4-Stream packet, with TLAST on the final word.
- A small internal FIFO absorbs sink backpressure, because the ADC side cannot be stalled. Words that do not fit are dropped and flagged.

Parameters:
- PKT_LEN_W, 16, width of the packet-length input; maximum packet is 2^PKT_LEN_W-1 words.
- FIFO_DEPTH, 4, number of FIFO entries; power of two, at least 2.

Ports:
- clk  in  1  single clock, shared with the upstream extender.
- resetn  in  1  synchronous active-low reset.
- indata  in  32  packed ADC word from the upstream extender.
- invalid  in  1  indata valid strobe; nominally high every second cycle.
- start  in  1  one-cycle capture request.
- pkt_len  in  PKT_LEN_W  number of words to capture; sampled on an accepted start.
- m_axis_tdata  out  32  stream data.
- m_axis_tvalid  out  1  stream valid.
- m_axis_tready  in  1  stream ready.
- m_axis_tlast  out  1  marks the last word of the packet.
- busy  out  1  high from an accepted start until the last word has been transferred.
- done  out  1  one-cycle pulse when the packet is complete.
- overflow  out  1  sticky flag: at least one word was dropped because the FIFO was full.

Behaviour:
- Reset: resetn is sampled only at posedge clk; all state is synchronous. While in reset:
  - FSM goes to IDLE; FIFO empties; word counter is cleared.
  - m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0, busy=0, done=0, overflow=0.
  - Reset asserted mid-packet aborts the packet. The partial packet is discarded, no TLAST is emitted, and the next packet after reset is clean.
- FSM states and transitions:
  - IDLE -> CAPTURE on start=1 with pkt_len!=0. In that cycle: load cnt<=pkt_len, clear overflow, set busy.
  - start with pkt_len==0 is ignored: no state change, no done.
  - In CAPTURE and DRAIN, start is ignored. pkt_len changes have no effect once sampled.
  - CAPTURE: each cycle with invalid=1 and a write accepted pushes {last, indata} and decrements cnt. last=1 when cnt==1.
  - CAPTURE -> DRAIN in the cycle after the word with last=1 is written.
  - invalid in the same cycle as the accepted start is not captured. Capture begins the next cycle.
  - DRAIN: invalid is ignored. DRAIN -> IDLE in the cycle after the TLAST beat transfers (tvalid & tready & tlast).
  - done pulses for one cycle on that DRAIN -> IDLE transition. busy falls in the same cycle done is high.
- FIFO write acceptance:
  - A write is accepted if count<FIFO_DEPTH, or if the FIFO is full and a pop occurs in the same cycle (simultaneous push/pop when full is allowed).
  - Otherwise the word is dropped and overflow<=1. A dropped word does not decrement cnt, so the packet still ends with exactly pkt_len delivered words and TLAST.
- AXI stream output:
  - m_axis_tvalid = FIFO not empty. tdata and tlast come from the head entry and are registered (FIFO storage output, no combinational path from indata).
  - Pop occurs on tvalid & tready. tdata and tlast hold stable while tvalid=1 and tready=0.
- Latency: an indata word written at edge N is visible on m_axis_tdata with tvalid=1 after edge N, i.e. one cycle, when the FIFO was empty.
- Pointers: read and write pointers are log2(FIFO_DEPTH)+1 bits and wrap naturally; full/empty come from the MSB compare.
- Counter: cnt is PKT_LEN_W bits and never decrements below 0.
- overflow is cleared only by reset or by an accepted start.

Optional Feature:
- Macro: ADC_CAPTURE_PACKER_TUSER_EN.
- Defined: adds output m_axis_tuser (1 bit). It is 1 on the first word of each packet (stored per FIFO entry, set on the first accepted write after start) and 0 otherwise. Reset value is 0.
  - For pkt_len==1, tuser and tlast are both 1 on the single beat.
- Undefined: the port does not exist and no extra FIFO bit is stored.

Test Plan:
- Basic packet: reset; pkt_len=4; start; invalid every second cycle with data 0x11110000..0x11110003; tready=1. Required: 4 beats in order, tlast only on 0x11110003, done pulses once, busy low afterwards, overflow=0.
- Backpressure within depth: pkt_len=6, tready=0 for 8 cycles then 1. Required: all 6 words delivered in order, tdata stable while stalled, overflow=0.
- Overflow: pkt_len=8, tready=0 for 20 cycles. Required: overflow=1. Delivered words are the first 4 captured plus later words, with exactly 8 beats and tlast on beat 8; overflow stays 1 until the next start.
- Boundary lengths: pkt_len=0 with start -> busy stays 0 and no done. pkt_len=1 -> single beat with tlast=1 (and tuser=1 when ADC_CAPTURE_PACKER_TUSER_EN is defined).
- Simultaneous events: start while busy is ignored (no restart, cnt unaffected). FIFO full with tready=1 and invalid=1 in the same cycle -> write accepted, no overflow.
- Reset mid-packet: resetn=0 for 1 cycle after 2 of 5 beats. Required: all outputs at reset values the next cycle; a subsequent start with pkt_len=3 gives exactly 3 beats with tlast on the third.

Source files
------------

// File: rtl/adc_capture_packer.sv
// Captures pkt_len ADC words on start and streams them out as one AXI4-Stream packet.
// Optional define ADC_CAPTURE_PACKER_TUSER_EN adds m_axis_tuser marking the first beat.
module adc_capture_packer #(
    parameter int PKT_LEN_W  = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic [31:0]          indata,
    input  logic                 invalid,
    input  logic                 start,
    input  logic [PKT_LEN_W-1:0] pkt_len,
    output logic [31:0]          m_axis_tdata,
    output logic                 m_axis_tvalid,
    input  logic                 m_axis_tready,
    output logic                 m_axis_tlast,
`ifdef ADC_CAPTURE_PACKER_TUSER_EN
    output logic                 m_axis_tuser,
`endif
    output logic                 busy,
    output logic                 done,
    output logic                 overflow
);

    localparam int AW = $clog2(FIFO_DEPTH);
`ifdef ADC_CAPTURE_PACKER_TUSER_EN
    localparam int EW = 34;
`else
    localparam int EW = 33;
`endif

    typedef enum logic [1:0] {IDLE, CAPTURE, DRAIN} state_t;

    state_t               state_q;
    logic [EW-1:0]        mem_q [FIFO_DEPTH];
    logic [AW:0]          wr_q, rd_q;
    logic [PKT_LEN_W-1:0] cnt_q;
    logic                 busy_q, done_q, ovf_q;
`ifdef ADC_CAPTURE_PACKER_TUSER_EN
    logic                 first_q;
`endif

    logic          empty, full, pop, push_req, accept, last_w;
    logic [EW-1:0] entry_d, head;

    assign empty    = (wr_q == rd_q);
    assign full     = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign pop      = !empty && m_axis_tready;
    assign push_req = (state_q == CAPTURE) && invalid;
    // A full FIFO still takes the word when the head leaves this cycle
    assign accept   = push_req && (!full || pop);
    assign last_w   = (cnt_q == PKT_LEN_W'(1));

`ifdef ADC_CAPTURE_PACKER_TUSER_EN
    assign entry_d      = {first_q, last_w, indata};
    assign m_axis_tuser = head[33];
`else
    assign entry_d = {last_w, indata};
`endif

    assign head          = mem_q[rd_q[AW-1:0]];
    assign m_axis_tdata  = head[31:0];
    assign m_axis_tlast  = head[32];
    assign m_axis_tvalid = !empty;
    assign busy          = busy_q;
    assign done          = done_q;
    assign overflow      = ovf_q;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= IDLE;
            wr_q    <= '0;
            rd_q    <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            ovf_q   <= 1'b0;
`ifdef ADC_CAPTURE_PACKER_TUSER_EN
            first_q <= 1'b0;
`endif
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            done_q <= 1'b0;
            if (accept) begin
                mem_q[wr_q[AW-1:0]] <= entry_d;
                wr_q                <= wr_q + (AW+1)'(1);
            end
            if (pop) begin
                rd_q <= rd_q + (AW+1)'(1);
            end
            unique case (state_q)
                IDLE: begin
                    if (start && (pkt_len != '0)) begin
                        state_q <= CAPTURE;
                        cnt_q   <= pkt_len;
                        ovf_q   <= 1'b0;
                        busy_q  <= 1'b1;
`ifdef ADC_CAPTURE_PACKER_TUSER_EN
                        first_q <= 1'b1;
`endif
                    end
                end
                CAPTURE: begin
                    if (accept) begin
                        cnt_q <= cnt_q - PKT_LEN_W'(1);
`ifdef ADC_CAPTURE_PACKER_TUSER_EN
                        first_q <= 1'b0;
`endif
                        if (last_w) begin
                            state_q <= DRAIN;
                        end
                    end else if (push_req) begin
                        ovf_q <= 1'b1;
                    end
                end
                DRAIN: begin
                    if (pop && m_axis_tlast) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_adc_capture_packer.sv
// Randomized bench for adc_capture_packer against a queue-level packet model.
// Optional define ADC_CAPTURE_PACKER_TUSER_EN also checks m_axis_tuser.
module tb_adc_capture_packer;

    localparam int DEPTH = 4;
    localparam int LIMIT = 2000;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic [31:0] indata = '0;
    logic        invalid = 1'b0;
    logic        start = 1'b0;
    logic [15:0] pkt_len = '0;
    logic [31:0] tdata;
    logic        tvalid;
    logic        tready = 1'b0;
    logic        tlast;
`ifdef ADC_CAPTURE_PACKER_TUSER_EN
    logic        tuser;
`endif
    logic        busy, done, overflow;

    always #5 clk = ~clk;

    adc_capture_packer #(.PKT_LEN_W(16), .FIFO_DEPTH(DEPTH)) dut (
        .clk           (clk),
        .resetn        (resetn),
        .indata        (indata),
        .invalid       (invalid),
        .start         (start),
        .pkt_len       (pkt_len),
        .m_axis_tdata  (tdata),
        .m_axis_tvalid (tvalid),
        .m_axis_tready (tready),
        .m_axis_tlast  (tlast),
`ifdef ADC_CAPTURE_PACKER_TUSER_EN
        .m_axis_tuser  (tuser),
`endif
        .busy          (busy),
        .done          (done),
        .overflow      (overflow)
    );

    typedef struct packed {
        logic        first;
        logic        last;
        logic [31:0] d;
    } ent_t;

    ent_t q[$];
    bit   m_busy, m_ovf, m_done, m_first;
    int   m_rem;
    int   beats;
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Packet-level reference: words captured while a packet still needs them,
    // dropped when the queue is full with no departure, delivered in order.
    task automatic cycle();
        ent_t e;
        bit   pop, want, acc, sacc;
        if (!resetn) begin
            q.delete();
            m_busy  = 0;
            m_rem   = 0;
            m_ovf   = 0;
            m_done  = 0;
            m_first = 0;
        end else begin
            pop    = (q.size() > 0) && tready;
            sacc   = !m_busy && start && (pkt_len != 0);
            want   = m_busy && (m_rem > 0) && invalid;
            acc    = want && ((q.size() < DEPTH) || pop);
            m_done = pop && q[0].last;
            if (pop) begin
                void'(q.pop_front());
                beats++;
            end
            if (acc) begin
                e.first = m_first;
                e.last  = (m_rem == 1);
                e.d     = indata;
                q.push_back(e);
                m_rem--;
                m_first = 0;
            end else if (want) begin
                m_ovf = 1;
            end
            if (m_done) m_busy = 0;
            if (sacc) begin
                m_busy  = 1;
                m_rem   = int'(pkt_len);
                m_ovf   = 0;
                m_first = 1;
            end
        end
        @(posedge clk);
        #1;
        chk("tvalid", 64'(tvalid), 64'(q.size() > 0));
        if (q.size() > 0) begin
            chk("tdata", 64'(tdata), 64'(q[0].d));
            chk("tlast", 64'(tlast), 64'(q[0].last));
`ifdef ADC_CAPTURE_PACKER_TUSER_EN
            chk("tuser", 64'(tuser), 64'(q[0].first));
`endif
        end
        chk("busy", 64'(busy), 64'(m_busy));
        chk("done", 64'(done), 64'(m_done));
        chk("overflow", 64'(overflow), 64'(m_ovf));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            start   = 0;
            invalid = i[0];
            indata  = $urandom;
            tready  = 1;
            cycle();
        end
    endtask

    task automatic reset_check();
        chk("rst_tvalid", 64'(tvalid), 64'd0);
        chk("rst_tdata", 64'(tdata), 64'd0);
        chk("rst_tlast", 64'(tlast), 64'd0);
`ifdef ADC_CAPTURE_PACKER_TUSER_EN
        chk("rst_tuser", 64'(tuser), 64'd0);
`endif
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_ovf", 64'(overflow), 64'd0);
    endtask

    // stall: cycles of tready=0 first; rnd: random tready afterwards;
    // dir: counting data pattern; abort: reset after that many beats (0=none)
    task automatic do_pkt(input int len, input int stall, input bit rnd,
                          input bit dir, input int abort, input int inv_mode);
        int k   = 0;
        int cyc = 0;
        beats   = 0;
        start   = 1;
        pkt_len = 16'(len);
        invalid = 1;
        indata  = 32'hDEAD0000;
        tready  = 1;
        cycle();
        start = 0;
        while (m_busy && cyc < LIMIT) begin
            invalid = (inv_mode == 0) ? ~cyc[0] : 1'($urandom_range(0, 1));
            indata  = dir ? 32'h11110000 + 32'(k) : $urandom;
            if (invalid) k++;
            tready  = (cyc < stall) ? 1'b0 : (rnd ? 1'($urandom_range(0, 1)) : 1'b1);
            start   = ($urandom_range(0, 7) == 0);
            pkt_len = 16'($urandom_range(1, 20));
            if (abort > 0 && beats == abort) begin
                resetn = 0;
                start  = 0;
                cycle();
                reset_check();
                resetn = 1;
                break;
            end
            cycle();
            cyc++;
        end
        chk("timeout", 64'(cyc < LIMIT), 64'd1);
        start = 0;
    endtask

    initial begin
        resetn = 0;
        cycle();
        cycle();
        reset_check();
        resetn = 1;
        idle(2);

        do_pkt(4, 0, 0, 1, 0, 0);
        idle(3);
        do_pkt(6, 8, 0, 0, 0, 0);
        idle(3);
        do_pkt(8, 20, 0, 0, 0, 0);
        chk("ovf_sticky", 64'(overflow), 64'd1);
        idle(3);
        do_pkt(0, 0, 0, 0, 0, 0);
        idle(3);
        do_pkt(1, 0, 0, 0, 0, 0);
        idle(3);
        do_pkt(5, 0, 0, 0, 2, 0);
        idle(2);
        do_pkt(3, 0, 0, 0, 0, 0);
        idle(2);
        for (int p = 0; p < 25; p++) begin
            do_pkt($urandom_range(1, 12), $urandom_range(0, 10), 1, 0, 0,
                   $urandom_range(0, 1));
            idle($urandom_range(0, 3));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
